// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared types for the SPI command controller: the command byte encoding,
// the decoder states and a width helper.
package spi_cmd_pkg;

  typedef enum logic [7:0] {
    SET_ST     = 8'h2a,
    SET_ST_ALL = 8'h2b,
    SET_GT     = 8'h2c,
    CH_SEL     = 8'h2d,
    REG_RD     = 8'h3a,
    CLR_ERR    = 8'h3f
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    GT_WR,
    CH_WR,
    RD
  } state_t;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_gt_shift_reg.sv
// Gate-time byte assembler: shifts bytes in MSB first, counts them, and
// flags the byte that completes a full gate time.
module gt_shift_reg
  import spi_cmd_pkg::*;
#(
  parameter  int unsigned GT_BYTES = 2,
  localparam int unsigned GT_W     = 8 * GT_BYTES
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            shift_i,
  input  logic [7:0]      byte_i,
  output logic            done_c,
  output logic [GT_W-1:0] value_c
);

  localparam int unsigned CNT_W = clog2_min1(GT_BYTES);

  logic [GT_W-1:0]  stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Low GT_W bits of {stage, byte} are the staging word after one more shift.
  assign value_c = GT_W'({stage_q, byte_i});
  assign done_c  = shift_i && (cnt_q == CNT_W'(GT_BYTES - 1));

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      stage_d = '0;
      cnt_d   = '0;
    end else if (shift_i) begin
      if (done_c) begin
        stage_d = '0;
        cnt_d   = '0;
      end else begin
        stage_d = value_c;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: turns command/data bytes from the SPI slave into
// per-channel gate starts, gate times, channel select and readback address.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter  int unsigned CH_NUM   = 4,
  parameter  int unsigned GT_BYTES = 2,
  parameter  int unsigned REG_NUM  = 6,
  parameter  int unsigned REG_AW   = 3,
  localparam int unsigned GT_W     = 8 * GT_BYTES,
  localparam int unsigned CH_W     = clog2_min1(CH_NUM)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   dc_i,
  input  logic                   spi_byte_vld_i,
  input  logic [7:0]             spi_byte_data_i,
  input  logic [CH_NUM-1:0]      gate_busy_i,
  output logic [CH_NUM-1:0]      gate_st_o,
  output logic [CH_NUM*GT_W-1:0] gate_time_o,
  output logic [CH_W-1:0]        ch_sel_o,
  output logic [REG_AW-1:0]      reg_rd_addr_o,
  output logic                   cmd_err_o
);

  state_t                  state_q, state_d;
  logic [CH_NUM-1:0]       gate_st_q, gate_st_d;
  logic [CH_NUM*GT_W-1:0]  gate_time_q, gate_time_d;
  logic [CH_W-1:0]         ch_sel_q, ch_sel_d;
  logic [REG_AW-1:0]       rd_addr_q, rd_addr_d;
  logic                    err_q, err_d;

  logic                    cmd_vld_c;
  logic                    gt_shift_c;
  logic                    gt_done_c;
  logic [GT_W-1:0]         gt_value_c;

  assign cmd_vld_c  = spi_byte_vld_i && !dc_i;
  assign gt_shift_c = spi_byte_vld_i && dc_i && (state_q == GT_WR);

  // Any command abandons a partially received gate time.
  gt_shift_reg #(
    .GT_BYTES (GT_BYTES)
  ) u_gt_shift_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cmd_vld_c),
    .shift_i (gt_shift_c),
    .byte_i  (spi_byte_data_i),
    .done_c  (gt_done_c),
    .value_c (gt_value_c)
  );

  always_comb begin
    state_d     = state_q;
    gate_st_d   = '0;
    gate_time_d = gate_time_q;
    ch_sel_d    = ch_sel_q;
    rd_addr_d   = rd_addr_q;
    err_d       = err_q;

    if (cmd_vld_c) begin
      state_d = IDLE;
      case (spi_byte_data_i)
        SET_ST: begin
          if (gate_busy_i[ch_sel_q]) err_d = 1'b1;
          else                       gate_st_d[ch_sel_q] = 1'b1;
        end
        SET_ST_ALL: begin
          gate_st_d = ~gate_busy_i;
          if (|gate_busy_i) err_d = 1'b1;
        end
        SET_GT:  state_d = GT_WR;
        CH_SEL:  state_d = CH_WR;
        REG_RD: begin
          rd_addr_d = '0;
          state_d   = RD;
        end
        CLR_ERR: err_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end else if (spi_byte_vld_i) begin
      case (state_q)
        GT_WR: begin
          if (gt_done_c) begin
            gate_time_d[int'(ch_sel_q)*GT_W +: GT_W] = gt_value_c;
            state_d = IDLE;
          end
        end
        CH_WR: begin
          if (spi_byte_data_i < 8'(CH_NUM)) ch_sel_d = CH_W'(spi_byte_data_i);
          else                              err_d    = 1'b1;
          state_d = IDLE;
        end
        RD: begin
          rd_addr_d = (rd_addr_q == REG_AW'(REG_NUM - 1)) ? '0
                                                          : rd_addr_q + REG_AW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gate_st_q   <= '0;
      gate_time_q <= '0;
      ch_sel_q    <= '0;
      rd_addr_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_st_q   <= gate_st_d;
      gate_time_q <= gate_time_d;
      ch_sel_q    <= ch_sel_d;
      rd_addr_q   <= rd_addr_d;
      err_q       <= err_d;
    end
  end

  assign gate_st_o     = gate_st_q;
  assign gate_time_o   = gate_time_q;
  assign ch_sel_o      = ch_sel_q;
  assign reg_rd_addr_o = rd_addr_q;
  assign cmd_err_o     = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed vector table, multi-cycle corner cases,
// then random byte streams checked against a queue-based reference model.
module tb_spi_cmd_ctrl;

  localparam int CH_NUM   = 4;
  localparam int GT_BYTES = 2;
  localparam int REG_NUM  = 6;
  localparam int REG_AW   = 3;
  localparam int GT_W     = 8 * GT_BYTES;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic                   dc_i;
  logic                   spi_byte_vld_i;
  logic [7:0]             spi_byte_data_i;
  logic [CH_NUM-1:0]      gate_busy_i;
  logic [CH_NUM-1:0]      gate_st_o;
  logic [CH_NUM*GT_W-1:0] gate_time_o;
  logic [1:0]             ch_sel_o;
  logic [REG_AW-1:0]      reg_rd_addr_o;
  logic                   cmd_err_o;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(
    .CH_NUM   (CH_NUM),
    .GT_BYTES (GT_BYTES),
    .REG_NUM  (REG_NUM),
    .REG_AW   (REG_AW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .dc_i            (dc_i),
    .spi_byte_vld_i  (spi_byte_vld_i),
    .spi_byte_data_i (spi_byte_data_i),
    .gate_busy_i     (gate_busy_i),
    .gate_st_o       (gate_st_o),
    .gate_time_o     (gate_time_o),
    .ch_sel_o        (ch_sel_o),
    .reg_rd_addr_o   (reg_rd_addr_o),
    .cmd_err_o       (cmd_err_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: protocol mode as a name, gate-time bytes in a queue.
  string      m_mode;
  logic [7:0] m_q[$];
  logic [3:0] m_gst;
  int         m_gt[CH_NUM];
  int         m_ch;
  int         m_addr;
  bit         m_err;

  function automatic logic [63:0] m_gt_packed();
    logic [63:0] p = '0;
    for (int k = 0; k < CH_NUM; k++) p[k*GT_W +: GT_W] = 16'(m_gt[k]);
    return p;
  endfunction

  task automatic model_reset();
    m_mode = "idle";
    m_q.delete();
    m_gst  = '0;
    for (int k = 0; k < CH_NUM; k++) m_gt[k] = 0;
    m_ch   = 0;
    m_addr = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] d, input logic [3:0] busy);
    m_gst = '0;
    if (!dc) begin
      m_q.delete();
      m_mode = "idle";
      case (d)
        8'h2a: if (busy[m_ch]) m_err = 1'b1; else m_gst[m_ch] = 1'b1;
        8'h2b: begin m_gst = ~busy; if (busy != 0) m_err = 1'b1; end
        8'h2c: m_mode = "gate";
        8'h2d: m_mode = "chan";
        8'h3a: begin m_addr = 0; m_mode = "read"; end
        8'h3f: m_err = 1'b0;
        default: ;
      endcase
    end else if (m_mode == "gate") begin
      m_q.push_back(d);
      if (m_q.size() == GT_BYTES) begin
        int v = 0;
        foreach (m_q[i]) v = v * 256 + int'(m_q[i]);
        m_gt[m_ch] = v;
        m_q.delete();
        m_mode = "idle";
      end
    end else if (m_mode == "chan") begin
      if (int'(d) < CH_NUM) m_ch = int'(d); else m_err = 1'b1;
      m_mode = "idle";
    end else if (m_mode == "read") begin
      m_addr = (m_addr + 1) % REG_NUM;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/gate_st"},   64'(gate_st_o),     64'(m_gst));
    chk({tag, "/gate_time"}, 64'(gate_time_o),   m_gt_packed());
    chk({tag, "/ch_sel"},    64'(ch_sel_o),      64'(m_ch));
    chk({tag, "/rd_addr"},   64'(reg_rd_addr_o), 64'(m_addr));
    chk({tag, "/cmd_err"},   64'(cmd_err_o),     64'(m_err));
  endtask

  // Present one byte for one clock; called and returns at a falling edge.
  task automatic send(input bit dc, input logic [7:0] d, input logic [3:0] busy);
    dc_i            = dc;
    spi_byte_data_i = d;
    gate_busy_i     = busy;
    spi_byte_vld_i  = 1'b1;
    @(negedge clk);
    spi_byte_vld_i  = 1'b0;
    model_byte(dc, d, busy);
  endtask

  task automatic idle();
    @(negedge clk);
    m_gst = '0;
  endtask

  // Reset while a SET_ST strobe is on the bus; the strobe must be dropped.
  task automatic do_reset(input string tag);
    rst_i           = 1'b1;
    dc_i            = 1'b0;
    spi_byte_data_i = 8'h2a;
    gate_busy_i     = '0;
    spi_byte_vld_i  = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    chk({tag, "/gate_st"},   64'(gate_st_o),     64'h0);
    chk({tag, "/gate_time"}, 64'(gate_time_o),   64'h0);
    chk({tag, "/ch_sel"},    64'(ch_sel_o),      64'h0);
    chk({tag, "/rd_addr"},   64'(reg_rd_addr_o), 64'h0);
    chk({tag, "/cmd_err"},   64'(cmd_err_o),     64'h0);
    rst_i          = 1'b0;
    spi_byte_vld_i = 1'b0;
  endtask

  typedef struct {
    bit          dc;
    logic [7:0]  d;
    logic [3:0]  busy;
    logic [3:0]  gst;
    logic [63:0] gt;
    logic [1:0]  ch;
    logic [2:0]  addr;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit dc, input logic [7:0] d, input logic [3:0] busy,
                              input logic [3:0] gst, input logic [63:0] gt,
                              input logic [1:0] ch, input logic [2:0] addr, input bit err);
    vec_t v;
    v.dc = dc; v.d = d; v.busy = busy; v.gst = gst;
    v.gt = gt; v.ch = ch; v.addr = addr; v.err = err;
    tbl.push_back(v);
  endfunction

  localparam logic [63:0] G = 64'h0000_1234_0000_0000;
  localparam logic [7:0] CMDS [7] = '{8'h2a, 8'h2b, 8'h2c, 8'h2d, 8'h3a, 8'h3f, 8'h00};

  initial begin
    rst_i           = 1'b1;
    dc_i            = 1'b0;
    spi_byte_vld_i  = 1'b0;
    spi_byte_data_i = 8'h00;
    gate_busy_i     = '0;
    model_reset();
    @(negedge clk);
    do_reset("reset");

    //   dc    byte   busy   gst    gate_time  ch  addr err
    add(1'b0, 8'h2d, 4'h0, 4'h0, 64'h0, 2'd0, 3'd0, 1'b0);
    add(1'b1, 8'h02, 4'h0, 4'h0, 64'h0, 2'd2, 3'd0, 1'b0);
    add(1'b0, 8'h2c, 4'h0, 4'h0, 64'h0, 2'd2, 3'd0, 1'b0);
    add(1'b1, 8'h12, 4'h0, 4'h0, 64'h0, 2'd2, 3'd0, 1'b0);
    add(1'b1, 8'h34, 4'h0, 4'h0, G,     2'd2, 3'd0, 1'b0);
    add(1'b1, 8'h99, 4'h0, 4'h0, G,     2'd2, 3'd0, 1'b0);
    add(1'b0, 8'h2a, 4'h0, 4'h4, G,     2'd2, 3'd0, 1'b0);
    add(1'b0, 8'h2c, 4'h0, 4'h0, G,     2'd2, 3'd0, 1'b0);
    add(1'b1, 8'hab, 4'h0, 4'h0, G,     2'd2, 3'd0, 1'b0);
    add(1'b0, 8'h3a, 4'h0, 4'h0, G,     2'd2, 3'd0, 1'b0);
    add(1'b1, 8'h10, 4'h0, 4'h0, G,     2'd2, 3'd1, 1'b0);
    add(1'b1, 8'h11, 4'h0, 4'h0, G,     2'd2, 3'd2, 1'b0);
    add(1'b1, 8'h12, 4'h0, 4'h0, G,     2'd2, 3'd3, 1'b0);
    add(1'b1, 8'h13, 4'h0, 4'h0, G,     2'd2, 3'd4, 1'b0);
    add(1'b1, 8'h14, 4'h0, 4'h0, G,     2'd2, 3'd5, 1'b0);
    add(1'b1, 8'h15, 4'h0, 4'h0, G,     2'd2, 3'd0, 1'b0);
    add(1'b1, 8'h16, 4'h0, 4'h0, G,     2'd2, 3'd1, 1'b0);
    add(1'b0, 8'h2a, 4'h0, 4'h4, G,     2'd2, 3'd1, 1'b0);
    add(1'b1, 8'h55, 4'h0, 4'h0, G,     2'd2, 3'd1, 1'b0);
    add(1'b0, 8'h2d, 4'h0, 4'h0, G,     2'd2, 3'd1, 1'b0);
    add(1'b1, 8'h04, 4'h0, 4'h0, G,     2'd2, 3'd1, 1'b1);
    add(1'b0, 8'h2a, 4'h4, 4'h0, G,     2'd2, 3'd1, 1'b1);
    add(1'b0, 8'h3f, 4'h0, 4'h0, G,     2'd2, 3'd1, 1'b0);
    add(1'b0, 8'h2b, 4'ha, 4'h5, G,     2'd2, 3'd1, 1'b1);
    add(1'b0, 8'h3f, 4'h0, 4'h0, G,     2'd2, 3'd1, 1'b0);
    add(1'b0, 8'h2d, 4'h0, 4'h0, G,     2'd2, 3'd1, 1'b0);
    add(1'b1, 8'h03, 4'h0, 4'h0, G,     2'd3, 3'd1, 1'b0);
    add(1'b0, 8'h2a, 4'h0, 4'h8, G,     2'd3, 3'd1, 1'b0);
    add(1'b0, 8'h2a, 4'h0, 4'h8, G,     2'd3, 3'd1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      send(tbl[i].dc, tbl[i].d, tbl[i].busy);
      chk({tag, "/gate_st"},   64'(gate_st_o),     64'(tbl[i].gst));
      chk({tag, "/gate_time"}, 64'(gate_time_o),   tbl[i].gt);
      chk({tag, "/ch_sel"},    64'(ch_sel_o),      64'(tbl[i].ch));
      chk({tag, "/rd_addr"},   64'(reg_rd_addr_o), 64'(tbl[i].addr));
      chk({tag, "/cmd_err"},   64'(cmd_err_o),     64'(tbl[i].err));
    end

    // Pulse from the last SET_ST must drop on a cycle without a strobe.
    idle();
    chk("pulse_end/gate_st", 64'(gate_st_o), 64'h0);

    // Reset in the middle of a gate-time write discards the partial byte.
    send(1'b0, 8'h2c, 4'h0);
    send(1'b1, 8'h77, 4'h0);
    do_reset("midwrite_reset");
    send(1'b1, 8'h11, 4'h0);
    send(1'b1, 8'h22, 4'h0);
    chk("post_reset_data/gate_time", 64'(gate_time_o), 64'h0);
    send(1'b0, 8'h2c, 4'h0);
    send(1'b1, 8'h11, 4'h0);
    send(1'b1, 8'h22, 4'h0);
    chk("post_reset_write/gate_time", 64'(gate_time_o), 64'h0000_0000_0000_1122);
    check_model("post_reset");

    // Random byte stream against the reference model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle();
      end else begin
        bit         dc;
        logic [7:0] d;
        logic [3:0] busy;
        dc = 1'($urandom_range(0, 1));
        if (!dc) begin
          d = CMDS[$urandom_range(0, 6)];
          if (d == 8'h00) d = 8'($urandom);
        end else begin
          d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
        end
        busy = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        send(dc, d, busy);
      end
      check_model($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
